// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer pattern writer.
//   DW         : pixel width (RGB 111)
//   *_VGA      : primary colour codes
//   state_e    : writer FSM encoding
//   bar_colour : colour of a bar index after rotation by an offset
package vga_pkg;

  localparam int unsigned DW = 3;

  localparam logic [DW-1:0] RED_VGA   = 3'b100;
  localparam logic [DW-1:0] GREEN_VGA = 3'b010;
  localparam logic [DW-1:0] BLUE_VGA  = 3'b001;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  // Eight bars, colour index wraps mod 8.
  function automatic logic [DW-1:0] bar_colour(logic [2:0] bar, logic [2:0] offset);
    return bar + offset;
  endfunction

endpackage

// File: rtl/vga_pattern_writer_if.sv
// Frame-buffer write bus between the pattern writer and the dual-port buffer.
//   addr_out : buffer write address
//   data_out : pixel written
//   regwrite : write strobe, one word per cycle
//   busy     : fill in progress or pending
interface vga_pattern_writer_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 3
);
  logic [AW-1:0] addr_out;
  logic [DW-1:0] data_out;
  logic          regwrite;
  logic          busy;

  modport master (
    output addr_out,
    output data_out,
    output regwrite,
    output busy
  );

  modport slave (
    input addr_out,
    input data_out,
    input regwrite,
    input busy
  );
endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and rising-edge pulse.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   btn_i   : raw active-high button, asynchronous to clk_i
//   pulse_o : one-cycle pulse on each accepted press
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    // Count consecutive cycles that disagree with the accepted level; any
    // agreeing cycle restarts the count.
    if (sync2_q != stable_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    pulse_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;
endmodule

// File: rtl/vga_pattern_writer.sv
// Fills the VGA frame buffer with eight rotating colour bars.
//   clk  : pixel clock
//   rst  : asynchronous active-low reset
//   bntr : raw button, rotate bars +1
//   bntl : raw button, rotate bars -1
//   bus  : frame-buffer write bus (addr_out, data_out, regwrite, busy)
module vga_pattern_writer
  import vga_pkg::*;
#(
  parameter int unsigned AW              = 8,
  parameter int unsigned DW              = vga_pkg::DW,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bntr,
  input  logic                 bntl,
  vga_pattern_writer_if.master bus
);
  logic r_pulse, l_pulse;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
    .clk_i  (clk),
    .rst_ni (rst),
    .btn_i  (bntr),
    .pulse_o(r_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
    .clk_i  (clk),
    .rst_ni (rst),
    .btn_i  (bntl),
    .pulse_o(l_pulse)
  );

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [2:0]    offset_q, offset_d;
  logic [2:0]    delta_q, delta_d;
  logic          pending_q, pending_d;
  logic          start;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    offset_d  = offset_q;
    delta_d   = delta_q;
    pending_d = pending_q;
    start     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d = FILL;
          start   = 1'b1;
        end
      end
      FILL: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == '1) begin
          if (pending_q) begin
            start = 1'b1;
          end else begin
            // Park on the last address so outputs hold while idle.
            state_d = IDLE;
            cnt_d   = cnt_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Offset only moves at a fill boundary, so each fill is uniform.
    if (start) begin
      cnt_d     = '0;
      offset_d  = offset_q + delta_q;
      delta_d   = '0;
      pending_d = 1'b0;
    end

    // Applied after the consume so a coinciding press starts a fresh delta.
    if (r_pulse && !l_pulse) begin
      delta_d   = delta_d + 3'd1;
      pending_d = 1'b1;
    end else if (l_pulse && !r_pulse) begin
      delta_d   = delta_d - 3'd1;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      offset_q  <= '0;
      delta_q   <= '0;
      pending_q <= 1'b1;  // forces the power-up fill
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      offset_q  <= offset_d;
      delta_q   <= delta_d;
      pending_q <= pending_d;
    end
  end

  assign bus.regwrite = (state_q == FILL);
  assign bus.addr_out = cnt_q;
  assign bus.data_out = DW'(bar_colour(cnt_q[AW-1 -: 3], offset_q));
  assign bus.busy     = (state_q == FILL) | pending_q;
endmodule
